// File: rtl/branch_predictor_if.sv
// Branch predictor bus: fetch-side lookup, resolve-side update, table
// invalidate and the two statistic counters. The master drives lookups and
// updates; the slave (the predictor) returns predictions and statistics.
interface branch_predictor_if;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        inval;
  logic [31:0] upd_count;
  logic [31:0] mispred_count;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, inval,
    input  pred_hit, pred_taken, pred_target, upd_count, mispred_count
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, inval,
    output pred_hit, pred_taken, pred_target, upd_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is purely combinational against the current table, so a
// same-cycle update to the same index is only seen from the next cycle.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  // Read views of the per-entry registers
  logic             valid_arr [ENTRIES];
  logic [TAG_W-1:0] tag_arr   [ENTRIES];
  logic [CTR_W-1:0] ctr_arr   [ENTRIES];
  logic [31:0]      tgt_arr   [ENTRIES];

  // Address decomposition; PC[1:0] never selects anything
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_bits;

  assign lk_idx         = bp.lookup_pc[IDX_W+1:2];
  assign lk_tag         = bp.lookup_pc[31:IDX_W+2];
  assign upd_idx        = bp.upd_pc[IDX_W+1:2];
  assign upd_tag        = bp.upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^bp.upd_pc[1:0];

  // Prediction: hit needs valid + tag match, taken follows counter MSB
  logic lk_hit;
  logic lk_taken;

  assign lk_hit         = valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
  assign lk_taken       = lk_hit && ctr_arr[lk_idx][CTR_W-1];
  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? tgt_arr[lk_idx] : (bp.lookup_pc + 32'd4);

  // Update-side hit test and trained counter value for the addressed entry
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_d;

  assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  assign ctr_cur = ctr_arr[upd_idx];

  // Saturating increment on taken, saturating decrement on not-taken
  always_comb begin
    ctr_d = ctr_cur;
    if (bp.upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_q;
      logic [TAG_W-1:0] tag_q;
      logic [CTR_W-1:0] ctr_q;
      logic [31:0]      tgt_q;
      logic             sel;

      assign sel = bp.upd_en && (upd_idx == IDX_W'(gi));

      // Entry state: reset, then invalidate, then train-on-hit / allocate-on-taken-miss
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          ctr_q   <= '0;
          tgt_q   <= '0;
        end else if (bp.inval) begin
          valid_q <= 1'b0;
        end else if (sel) begin
          if (upd_hit) begin
            ctr_q <= ctr_d;
            if (bp.upd_taken) tgt_q <= bp.upd_target;
          end else if (bp.upd_taken) begin
            valid_q <= 1'b1;
            tag_q   <= upd_tag;
            ctr_q   <= CTR_WEAK;
            tgt_q   <= bp.upd_target;
          end
        end
      end

      assign valid_arr[gi] = valid_q;
      assign tag_arr[gi]   = tag_q;
      assign ctr_arr[gi]   = ctr_q;
      assign tgt_arr[gi]   = tgt_q;
    end
  endgenerate

  // Statistics, saturating at all-ones
  logic [31:0] upd_count_q;
  logic [31:0] upd_count_d;
  logic [31:0] mispred_count_q;
  logic [31:0] mispred_count_d;

  // Next-state for the statistic counters; invalidate does not gate counting
  always_comb begin
    upd_count_d     = upd_count_q;
    mispred_count_d = mispred_count_q;
    if (bp.upd_en) begin
      if (upd_count_q != 32'hFFFF_FFFF) upd_count_d = upd_count_q + 32'd1;
      if (bp.upd_mispred && (mispred_count_q != 32'hFFFF_FFFF))
        mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  // Statistic registers; reset discards any coincident update
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bp.upd_count     = upd_count_q;
  assign bp.mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of table entries; power of two, 4..256.
REQ-002 SHALL have parameter CTR_W, default 2, width of each saturating direction counter; 2..4.
REQ-003 SHALL use a single clock; reset SHALL be synchronous and active-low.
REQ-004 Port CLK  input  1  clock; all state updates on rising edge.
REQ-005 Port nRST  input  1  synchronous active-low reset.
REQ-006 Port lookup_pc  input  32  fetch PC to predict.
REQ-007 Port pred_hit  output  1  valid entry with matching tag for lookup_pc.
REQ-008 Port pred_taken  output  1  predict taken.
REQ-009 Port pred_target  output  32  next fetch address.
REQ-010 Port upd_en  input  1  resolved branch/jump this cycle.
REQ-011 Port upd_pc  input  32  PC of resolved instruction.
REQ-012 Port upd_taken  input  1  actual outcome.
REQ-013 Port upd_target  input  32  actual taken target.
REQ-014 Port upd_mispred  input  1  pipeline flushed for this instruction; qualified by upd_en.
REQ-015 Port inval  input  1  invalidate entire table.
REQ-016 Port upd_count  output  32  number of accepted updates.
REQ-017 Port mispred_count  output  32  number of accepted mispredicted updates.

Function
REQ-018 Index SHALL be PC[IDX_W+1:2] with IDX_W = log2(ENTRIES); tag SHALL be PC[31:IDX_W+2]; PC[1:0] ignored.
REQ-019 Each entry SHALL hold valid bit, tag, CTR_W-bit counter, 32-bit target.
REQ-020 Lookup SHALL be combinational from lookup_pc and current table state; zero-cycle latency.
REQ-021 pred_hit SHALL equal valid & (stored tag == lookup tag).
REQ-022 pred_taken SHALL equal pred_hit & counter MSB.
REQ-023 pred_target SHALL be stored target when pred_taken, else lookup_pc + 4 (32-bit wrap).
REQ-024 Update SHALL take effect at the rising edge where upd_en=1; visible to lookups from the next cycle.
REQ-025 Same-cycle lookup and update to the same index SHALL return pre-update contents.
REQ-026 Update hit (valid, tag match): counter +1 saturating at 2^CTR_W-1 when taken, -1 saturating at 0 when not taken; target overwritten only when taken.
REQ-027 Update miss, taken: allocate entry (overwrite any occupant), valid=1, tag=upd tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken).
REQ-028 Update miss, not taken: table unchanged.
REQ-029 upd_count SHALL increment by 1 per accepted update; mispred_count SHALL increment when upd_en & upd_mispred; both saturate at 32'hFFFFFFFF.
REQ-030 inval=1 SHALL clear all valid bits at that edge; counters, targets and statistic counters unchanged.
REQ-031 inval and upd_en in the same cycle: invalidate wins for the table; statistic counters still count the update.
REQ-032 Updates with upd_en=0 SHALL not modify any state regardless of other upd_* inputs.

Reset
REQ-033 nRST=0 at a rising edge SHALL clear all valid bits, all direction counters to 0, targets and tags to 0, upd_count and mispred_count to 0.
REQ-034 Reset SHALL override inval and upd_en in the same cycle; update discarded and not counted.
REQ-035 After reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.

Verification
REQ-036 Cold lookup: after reset, lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044, counts 0.
REQ-037 Allocate/train: update pc=0x40 taken target=0x100 -> next cycle lookup 0x40 gives hit=1, taken=1, target=0x100; one not-taken update -> counter 2'b01, taken=0, target=0x44.
REQ-038 Saturation: four taken updates to 0x40 -> counter 2'b11; five not-taken -> counter 2'b00, entry still valid, pred_hit=1.
REQ-039 Aliasing: ENTRIES=16, entry for 0x40 allocated; taken update at 0x80 (same index, different tag) replaces it -> lookup 0x40 hit=0, lookup 0x80 hit=1.
REQ-040 Same-cycle: lookup 0x40 and taken-miss update 0x40 same cycle -> hit=0 that cycle, hit=1 next cycle; then inval -> hit=0 next cycle, upd_count unchanged by inval.
REQ-041 Reset mid-operation: nRST low coincident with upd_en=1, upd_mispred=1 after 3 counted updates -> all counts 0, table empty next cycle.
